// File: rtl/key_pkg.sv
// Shared definitions for the key event decoder: state encodings and default timing.
package key_pkg;

   // One clk_1k cycle is one millisecond; all *_MS timings count clock cycles.
   localparam int unsigned TICK_US = 1000;

   localparam int unsigned LONG_MS_DEF       = 1000;
   localparam int unsigned REPEAT_MS_DEF     = 200;
   localparam int unsigned DOUBLE_GAP_MS_DEF = 300;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS,
      ST_LONG,
      ST_GAP,
      ST_WAIT_REL
   } key_state_e;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/key_event_decoder.sv
// Key event decoder: classifies a debounced active-low key into short, long,
// auto-repeat and double-click events, all as registered one-cycle pulses.
module key_event_decoder
   import key_pkg::*;
#(
   parameter int unsigned LONG_MS       = LONG_MS_DEF,
   parameter int unsigned REPEAT_MS     = REPEAT_MS_DEF,
   parameter int unsigned DOUBLE_GAP_MS = DOUBLE_GAP_MS_DEF,
   parameter bit          DOUBLE_EN     = 1'b1
) (
   input  logic clk_1k,
   input  logic rst_n,
   input  logic key_n,
   input  logic enable,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic double_pulse,
   output logic held
);

   // PRESS sees cnt==LONG_MS-1 on the last held sample before the long event.
   localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_MS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_MS);
   localparam logic [CNT_W-1:0] GAP_LIM    = CNT_W'(DOUBLE_GAP_MS);

   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             prev_q, prev_d;
   logic             arm_q, arm_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             double_q, double_d;
   logic             held_q, held_d;
   logic             press_edge;

   // prev resets to 1, so a key already held across reset would look like a
   // fresh edge; arm stays low until the key has been seen released.
   always_comb begin
      prev_d     = key_n;
      arm_d      = arm_q | key_n;
      press_edge = prev_q & ~key_n & arm_q;
   end

   // Next-state, counter and pulse decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      double_d = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (press_edge) begin
                  state_d = ST_PRESS;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_PRESS: begin
               if (key_n) begin
                  if (DOUBLE_EN) begin
                     state_d = ST_GAP;
                     cnt_d   = CNT_W'(1);
                  end else begin
                     state_d = ST_IDLE;
                     cnt_d   = '0;
                     short_d = 1'b1;
                  end
               end else if (cnt_q == LONG_LIM) begin
                  state_d = ST_LONG;
                  cnt_d   = CNT_W'(1);
                  long_d  = 1'b1;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_LONG: begin
               if (key_n) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == REPEAT_LIM) begin
                  cnt_d    = CNT_W'(1);
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_GAP: begin
               // A re-press on the expiry cycle still counts as a double click.
               if (press_edge) begin
                  state_d  = ST_WAIT_REL;
                  cnt_d    = '0;
                  double_d = 1'b1;
               end else if (cnt_q >= GAP_LIM) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
                  short_d = 1'b1;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_WAIT_REL: begin
               if (key_n) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      held_d = (state_d == ST_LONG);
   end

   // State, counter, edge history and registered outputs.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         prev_q   <= 1'b1;
         arm_q    <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         repeat_q <= 1'b0;
         double_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_q   <= prev_d;
         arm_q    <= arm_d;
         short_q  <= short_d;
         long_q   <= long_d;
         repeat_q <= repeat_d;
         double_q <= double_d;
         held_q   <= held_d;
      end
   end

   assign short_pulse  = short_q;
   assign long_pulse   = long_q;
   assign repeat_pulse = repeat_q;
   assign double_pulse = double_q;
   assign held         = held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder: one instance with double-click enabled,
// one with it disabled, driven by the same key/enable/reset.
module tb_key_event_decoder;

   logic clk_1k = 1'b0;
   logic rst_n, key_n, enable;
   logic s1, l1, r1, d1, h1;
   logic s0, l0, r0, d0, h0;

   int n_vec  = 0;
   int n_miss = 0;
   bit sel0   = 1'b0;
   int t, c_s, c_l, c_r, c_d, c_h, f_s, f_l, f_r, f_d, l_r;
   int g_multi = 0;

   always #500 clk_1k = ~clk_1k;

   key_event_decoder dut (
      .clk_1k(clk_1k), .rst_n(rst_n), .key_n(key_n), .enable(enable),
      .short_pulse(s1), .long_pulse(l1), .repeat_pulse(r1),
      .double_pulse(d1), .held(h1)
   );

   key_event_decoder #(.DOUBLE_EN(1'b0)) dut0 (
      .clk_1k(clk_1k), .rst_n(rst_n), .key_n(key_n), .enable(enable),
      .short_pulse(s0), .long_pulse(l0), .repeat_pulse(r0),
      .double_pulse(d0), .held(h0)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      t = 0; c_s = 0; c_l = 0; c_r = 0; c_d = 0; c_h = 0;
      f_s = -1; f_l = -1; f_r = -1; f_d = -1; l_r = -1;
   endtask

   // Advance n cycles, sampling the selected instance 1 time unit after each edge.
   task automatic step_n(input int n);
      logic s, l, r, d, h;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_1k);
         #1;
         t++;
         if (sel0) begin
            s = s0; l = l0; r = r0; d = d0; h = h0;
         end else begin
            s = s1; l = l1; r = r1; d = d1; h = h1;
         end
         if (s) begin c_s++; if (f_s < 0) f_s = t; end
         if (l) begin c_l++; if (f_l < 0) f_l = t; end
         if (r) begin c_r++; if (f_r < 0) f_r = t; l_r = t; end
         if (d) begin c_d++; if (f_d < 0) f_d = t; end
         if (h) c_h++;
         if (int'(s) + int'(l) + int'(r) + int'(d) > 1) g_multi++;
      end
   endtask

   initial begin
      rst_n = 1'b0; key_n = 1'b1; enable = 1'b1;
      clear_stats();
      #100;
      check_val("rst_outputs", int'({s1, l1, r1, d1, h1, s0, l0, r0, d0, h0}), 0);
      step_n(2);
      rst_n = 1'b1;
      step_n(5);

      // Short press with double-click enabled: short after the gap window.
      clear_stats();
      key_n = 1'b0; step_n(100);
      key_n = 1'b1; step_n(400);
      check_val("short_cnt", c_s, 1);
      check_val("short_time", f_s, 401);
      check_val("short_no_long", c_l + c_r + c_d, 0);

      // Long hold with auto-repeat.
      clear_stats();
      key_n = 1'b0; step_n(1500);
      key_n = 1'b1; step_n(400);
      check_val("long_cnt", c_l, 1);
      check_val("long_time", f_l, 1000);
      check_val("rep_cnt", c_r, 2);
      check_val("rep_first", f_r, 1200);
      check_val("rep_last", l_r, 1400);
      check_val("held_cycles", c_h, 501);
      check_val("long_no_short", c_s + c_d, 0);

      // Double click with a long second hold.
      clear_stats();
      key_n = 1'b0; step_n(50);
      key_n = 1'b1; step_n(200);
      key_n = 1'b0; step_n(2000);
      key_n = 1'b1; step_n(400);
      check_val("dbl_cnt", c_d, 1);
      check_val("dbl_time", f_d, 251);
      check_val("dbl_no_other", c_s + c_l + c_r + c_h, 0);

      // Re-press exactly on the last gap cycle: still a double click.
      clear_stats();
      key_n = 1'b0; step_n(50);
      key_n = 1'b1; step_n(300);
      key_n = 1'b0; step_n(50);
      key_n = 1'b1; step_n(400);
      check_val("gap_edge_dbl", c_d, 1);
      check_val("gap_edge_time", f_d, 351);
      check_val("gap_edge_short", c_s, 0);

      // Re-press one cycle too late: two separate short presses.
      clear_stats();
      key_n = 1'b0; step_n(50);
      key_n = 1'b1; step_n(301);
      key_n = 1'b0; step_n(50);
      key_n = 1'b1; step_n(400);
      check_val("gap_late_short", c_s, 2);
      check_val("gap_late_time", f_s, 351);
      check_val("gap_late_dbl", c_d, 0);

      // Double-click disabled instance: short right after release.
      sel0 = 1'b1;
      clear_stats();
      key_n = 1'b0; step_n(100);
      key_n = 1'b1; step_n(50);
      check_val("nodbl_short_cnt", c_s, 1);
      check_val("nodbl_short_time", f_s, 101);
      check_val("nodbl_other", c_l + c_r + c_d, 0);
      sel0 = 1'b0;
      step_n(400);

      // Enable dropped mid-press, restored while still held.
      clear_stats();
      key_n = 1'b0; step_n(500);
      enable = 1'b0; step_n(100);
      enable = 1'b1; step_n(900);
      key_n = 1'b1; step_n(400);
      check_val("en_no_pulses", c_s + c_l + c_r + c_d + c_h, 0);
      clear_stats();
      key_n = 1'b0; step_n(100);
      key_n = 1'b1; step_n(400);
      check_val("en_after_short", c_s, 1);
      check_val("en_after_time", f_s, 401);

      // Reset while in LONG: held clears asynchronously, no events afterwards.
      clear_stats();
      key_n = 1'b0; step_n(1100);
      check_val("pre_rst_held", int'(h1), 1);
      rst_n = 1'b0;
      #1;
      check_val("rst_async_held", int'(h1), 0);
      step_n(3);
      rst_n = 1'b1; step_n(2000);
      key_n = 1'b1; step_n(400);
      check_val("rst_long_cnt", c_l, 1);
      check_val("rst_long_rep", c_r, 0);
      check_val("rst_long_short", c_s + c_d, 0);

      // Reset at edge+800 of a press, key kept held afterwards.
      clear_stats();
      key_n = 1'b0; step_n(800);
      rst_n = 1'b0;
      #1;
      check_val("rst_mid_outputs", int'({s1, l1, r1, d1, h1}), 0);
      step_n(3);
      rst_n = 1'b1; step_n(2000);
      key_n = 1'b1; step_n(400);
      check_val("rst_mid_no_pulse", c_s + c_l + c_r + c_d + c_h, 0);

      check_val("one_hot_pulses", g_multi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_MS, 1000, press duration in clk_1k cycles that produces a long press (range 2..65535).
REQ-002 Parameter REPEAT_MS, 200, auto-repeat period in cycles while the key is held after a long press (range 2..65535).
REQ-003 Parameter DOUBLE_GAP_MS, 300, maximum release-to-repress gap in cycles for a double click (range 2..65535).
REQ-004 Parameter DOUBLE_EN, 1, 1 enables double-click detection, 0 disables it.
REQ-005 clk_1k  input  1  1 kHz system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 key_n  input  1  debounced key level, active-low (0 = pressed), synchronous to clk_1k.
REQ-008 enable  input  1  1 = decode events; 0 = hold decoder idle.
REQ-009 short_pulse  output  1  one-cycle pulse on a short press.
REQ-010 long_pulse  output  1  one-cycle pulse when a press reaches LONG_MS.
REQ-011 repeat_pulse  output  1  one-cycle pulse per REPEAT_MS while held after a long press.
REQ-012 double_pulse  output  1  one-cycle pulse on a double click.
REQ-013 held  output  1  level, 1 while in state LONG.

Function
REQ-014 A register prev samples key_n every cycle regardless of enable; a press edge is a cycle with prev=1 and key_n=0, a release is any cycle with key_n=1.
REQ-015 The FSM has states IDLE, PRESS, LONG, GAP and WAIT_REL, with a single 16-bit cycle counter cnt.
REQ-016 IDLE: on a press edge, go to PRESS with cnt=1; otherwise stay.
REQ-017 PRESS: while key_n=0, increment cnt; when a press edge sampled at cycle T0 is held low through cycle T0+LONG_MS-1, assert long_pulse at T0+LONG_MS and go to LONG with cnt=1.
REQ-018 PRESS: on a release sampled at cycle R, go to GAP with cnt=1 if DOUBLE_EN=1; otherwise go to IDLE and assert short_pulse at R+1.
REQ-019 LONG: while key_n=0, assert repeat_pulse at T0+LONG_MS+k*REPEAT_MS for k=1,2,...; on a release, go to IDLE with no short_pulse.
REQ-020 GAP: on a press edge sampled at cycle P with P-R <= DOUBLE_GAP_MS, assert double_pulse at P+1 and go to WAIT_REL.
REQ-021 GAP: if no press edge arrives by cycle R+DOUBLE_GAP_MS, assert short_pulse at R+DOUBLE_GAP_MS+1 and go to IDLE.
REQ-022 WAIT_REL: ignore hold duration (no long or repeat pulses); on a release, go to IDLE.
REQ-023 All outputs are registered; at most one of the four pulse outputs is high in any cycle, and each pulse lasts exactly one cycle.
REQ-024 While enable=0, the FSM is forced to IDLE, cnt is cleared and all outputs are 0; an in-flight event is discarded.
REQ-025 After enable returns to 1 with the key already held, no event is produced until a release followed by a new press edge.
REQ-026 cnt saturates and never wraps; a press edge in PRESS or LONG cannot occur, and if one is seen in GAP on the same cycle the gap expires, double_pulse takes priority over short_pulse.

Reset
REQ-027 rst_n=0 asynchronously sets state=IDLE, cnt=0, prev=1, and all outputs to 0.
REQ-028 Reset asserted mid-press discards the event; after release of rst_n with key_n=0, the REQ-025 behaviour applies.

Structure
REQ-029 A shared header key_pkg holds the FSM state encodings and the default timing constants; the tick-rate assumption of 1 cycle = 1 ms is defined there.
REQ-030 A single module with no sub-modules; edge detection and the counter are inline.

Verification
REQ-031 DOUBLE_EN=1: press for 100 cycles, then release -> exactly one short_pulse, 301 cycles after the release sample; no other pulses.
REQ-032 Hold for 1500 cycles -> long_pulse at edge+1000, repeat_pulse at edge+1200 and edge+1400, held=1 over that span; release produces no short_pulse.
REQ-033 Press 50 cycles, release 200 cycles, press 50 cycles -> double_pulse one cycle after the second edge; no short_pulse, long_pulse or repeat_pulse, including for a 2000-cycle second hold.
REQ-034 DOUBLE_EN=0: press 100 cycles then release -> short_pulse on the cycle after the release sample.
REQ-035 Drop enable at edge+500 of a held press, raise it again at edge+600 while still held -> no pulses until release and a new press edge.
REQ-036 Assert rst_n low at edge+800 of a press -> all outputs 0 immediately; after reset release, continued holding produces no long_pulse.
